// File: rtl/fir_pkg.sv
// fir_pkg: shared state type and arithmetic helpers for fir_direct_param.
// FIR_SATURATE_EN selects clamping instead of two's-complement wrap.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        MAC,
        OUT
    } fir_state_e;

    localparam int RW = 128;

`ifdef FIR_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Round half up, shift, then clamp to dw bits when saturation is built in.
    function automatic logic signed [RW-1:0] round_sat(
        input logic signed [RW-1:0] acc,
        input int                   shift,
        input int                   dw
    );
        logic signed [RW-1:0] one;
        logic signed [RW-1:0] r;
        logic signed [RW-1:0] hi;
        logic signed [RW-1:0] lo;
        one = 1;
        r   = acc;
        if (shift > 0) begin
            r = r + (one <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (one <<< (dw - 1)) - one;
        lo = -hi - one;
        if (SAT_EN) begin
            if (r > hi) begin
                r = hi;
            end else if (r < lo) begin
                r = lo;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: TAPS x COEF_W coefficient registers, gated write port,
// combinational read at the MAC tap index.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int TAPS   = 33,
    parameter int COEF_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic signed [COEF_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic signed [COEF_W-1:0] rdata_o
);

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic                     wr_ok;

    assign wr_ok   = we_i & ({1'b0, waddr_i} < (ADDR_W + 1)'(TAPS));
    assign rdata_o = coef_q[raddr_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            coef_q <= '{default: '0};
        end else if (wr_ok) begin
            coef_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/fir_direct_param.sv
// fir_direct_param: time-multiplexed direct-form FIR, one MAC per tap.
// Build with FIR_SATURATE_EN to clamp the output instead of wrapping.
module fir_direct_param
    import fir_pkg::*;
#(
    parameter int TAPS      = 33,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int OUT_SHIFT = 15,
    parameter int ADDR_W    = 6
) (
    input  logic                     iClk_12M,
    input  logic                     iRsn,
    input  logic                     iCoeffiUpdateFlag,
    input  logic                     iCsnRam,
    input  logic                     iWrnRam,
    input  logic [ADDR_W-1:0]        iAddrRam,
    input  logic signed [COEF_W-1:0] iWrDtRam,
    input  logic                     iFirValid,
    output logic                     oFirReady,
    input  logic signed [DATA_W-1:0] iFirIn,
    output logic                     oFirValid,
    output logic signed [DATA_W-1:0] oFirOut,
    output logic                     oUpdBusy
);

    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

    fir_state_e               state_q, state_d;
    logic [ADDR_W-1:0]        k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     valid_q, valid_d;
    logic signed [DATA_W-1:0] x_q [TAPS];

    logic                     accept;
    logic                     coef_we;
    logic signed [COEF_W-1:0] coef_k;
    logic signed [ACC_W-1:0]  prod;

    assign oFirReady = (state_q == IDLE) & ~iCoeffiUpdateFlag;
    assign accept    = iFirValid & oFirReady;
    assign oUpdBusy  = (state_q == UPDATE);
    assign coef_we   = (state_q == UPDATE) & ~iCsnRam & ~iWrnRam;
    assign oFirValid = valid_q;
    assign oFirOut   = out_q;

    // Operands are widened first so the product is exact in ACC_W bits.
    assign prod = ACC_W'(coef_k) * ACC_W'(x_q[k_q]);

    fir_coef_bank #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .ADDR_W (ADDR_W)
    ) u_coef_bank (
        .clk_i   (iClk_12M),
        .rst_ni  (iRsn),
        .we_i    (coef_we),
        .waddr_i (iAddrRam),
        .wdata_i (iWrDtRam),
        .raddr_i (k_q),
        .rdata_o (coef_k)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iCoeffiUpdateFlag) begin
                    state_d = UPDATE;
                end else if (accept) begin
                    state_d = MAC;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            UPDATE: begin
                if (!iCoeffiUpdateFlag) begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                acc_d = acc_q + prod;
                k_d   = k_q + ADDR_W'(1);
                if (k_q == ADDR_W'(TAPS - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_d   = DATA_W'(round_sat(RW'(acc_q), OUT_SHIFT, DATA_W));
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // x_q[0] always holds the newest accepted sample.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            x_q <= '{default: '0};
        end else if (accept) begin
            x_q[0] <= iFirIn;
            for (int i = 1; i < TAPS; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fir_direct_param.sv
// tb_fir_direct_param: random and directed stimulus against a convolution
// model of the filter, with latency, handshake and reset checks.
module tb_fir_direct_param;

    localparam int TAPS = 33;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int SH   = 15;
    localparam int AW   = 6;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          upd    = 1'b0;
    logic          csn    = 1'b1;
    logic          wrn    = 1'b1;
    logic [AW-1:0] addr   = '0;
    logic [CW-1:0] wdata  = '0;
    logic          fvalid = 1'b0;
    logic [DW-1:0] din    = '0;
    logic          fready;
    logic          ovalid;
    logic [DW-1:0] dout;
    logic          busy;

    always #5 clk = ~clk;

    fir_direct_param #(
        .TAPS      (TAPS),
        .DATA_W    (DW),
        .COEF_W    (CW),
        .OUT_SHIFT (SH),
        .ADDR_W    (AW)
    ) dut (
        .iClk_12M          (clk),
        .iRsn              (rst_n),
        .iCoeffiUpdateFlag (upd),
        .iCsnRam           (csn),
        .iWrnRam           (wrn),
        .iAddrRam          (addr),
        .iWrDtRam          (wdata),
        .iFirValid         (fvalid),
        .oFirReady         (fready),
        .iFirIn            (din),
        .oFirValid         (ovalid),
        .oFirOut           (dout),
        .oUpdBusy          (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    longint coef_m [TAPS];
    longint hist   [TAPS];

    typedef struct {
        logic [DW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t          exp_q [$];
    int            acc_log [$];
    int            cyc = 0;
    logic [DW-1:0] last_out = '0;

    function automatic logic [DW-1:0] model_out();
        longint acc;
        longint hi;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc += coef_m[k] * hist[k];
        end
        acc = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
        hi  = (longint'(1) <<< (DW - 1)) - 1;
`ifdef FIR_SATURATE_EN
        if (acc > hi) begin
            acc = hi;
        end else if (acc < -hi - 1) begin
            acc = -hi - 1;
        end
`endif
        return acc[DW-1:0];
    endfunction

    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst_n && fvalid && fready) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                hist[k] = hist[k-1];
            end
            hist[0] = longint'($signed(din));
            e.val   = model_out();
            e.cyc   = cyc;
            exp_q.push_back(e);
            acc_log.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_out = '0;
        end else if (ovalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", ovalid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("dout", dout, e.val);
                check("latency", cyc - e.cyc + 1, TAPS + 2);
            end
            last_out = dout;
        end else begin
            check("hold", dout, last_out);
        end
    end

    task automatic wr(input int a, input logic [CW-1:0] v, input bit in_upd);
        @(negedge clk);
        addr  = AW'(a);
        wdata = v;
        csn   = 1'b0;
        wrn   = 1'b0;
        @(posedge clk);
        #1;
        csn = 1'b1;
        wrn = 1'b1;
        if (in_upd && a < TAPS) begin
            coef_m[a] = longint'($signed(v));
        end
    endtask

    task automatic open_upd();
        int n = 0;
        @(negedge clk);
        upd = 1'b1;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("upd_open", busy, 1'b1);
    endtask

    task automatic close_upd();
        @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        check("upd_close", busy, 1'b0);
    endtask

    task automatic load_const(input logic [CW-1:0] v);
        open_upd();
        for (int k = 0; k < TAPS; k++) begin
            wr(k, v, 1'b1);
        end
        close_upd();
    endtask

    task automatic load_rand();
        open_upd();
        for (int k = 0; k < TAPS; k++) begin
            wr(k, CW'($urandom), 1'b1);
        end
        close_upd();
    endtask

    task automatic send(input logic [DW-1:0] x);
        int n = 0;
        @(negedge clk);
        din    = x;
        fvalid = 1'b1;
        while (!fready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", n < 200, 1'b1);
        @(posedge clk);
        #1;
        fvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int highs;
        repeat (3) @(negedge clk);
        check("rst_ready", fready, 1'b1);
        check("rst_valid", ovalid, 1'b0);
        check("rst_out", dout, '0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // impulse response
        load_const(16'h4000);
        send(16'h2000);
        repeat (40) send('0);
        drain();

        // tap ordering: each tap scaled differently
        open_upd();
        for (int k = 0; k < TAPS; k++) begin
            wr(k, CW'((k + 1) * 256), 1'b1);
        end
        close_upd();
        send(16'h4000);
        repeat (TAPS + 1) send('0);
        drain();

        // random coefficients and samples
        load_rand();
        repeat (25) send(DW'($urandom));
        drain();

        // full-scale accumulation
        load_const(16'h7fff);
        repeat (TAPS + 2) send(16'h7fff);
        drain();

        // write outside UPDATE must not land
        load_rand();
        wr(0, 16'h7fff, 1'b0);
        repeat (3) send(DW'($urandom));
        drain();

        // out-of-range address in UPDATE must not land
        open_upd();
        wr(40, 16'h1234, 1'b1);
        wr(1, CW'($urandom), 1'b1);
        close_upd();
        repeat (3) send(DW'($urandom));
        drain();

        // flag raised mid-MAC: old coefficients finish the sample
        send(DW'($urandom));
        repeat (5) @(negedge clk);
        upd = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_midmac", busy, 1'b0);
        open_upd();
        for (int k = 0; k < 4; k++) begin
            wr(k, CW'($urandom), 1'b1);
        end
        close_upd();
        send(DW'($urandom));
        drain();

        // flag and valid together: UPDATE wins, nothing accepted
        @(negedge clk);
        upd    = 1'b1;
        fvalid = 1'b1;
        din    = 16'h1111;
        #1;
        check("ready_flag", fready, 1'b0);
        @(posedge clk);
        #1;
        check("busy_flag", busy, 1'b1);
        fvalid = 1'b0;
        close_upd();
        repeat (40) @(negedge clk);
        check("no_accept_flag", exp_q.size(), 0);

        // continuous valid: one accept per TAPS+2 cycles
        acc_log.delete();
        @(negedge clk);
        fvalid = 1'b1;
        din    = DW'($urandom);
        highs  = 0;
        for (int i = 1; i <= 3 * (TAPS + 2); i++) begin
            @(negedge clk);
            din = DW'($urandom);
            if (fready) begin
                highs++;
            end
        end
        fvalid = 1'b0;
        check("ready_highs", highs, 3);
        check("accepts", acc_log.size(), 3);
        for (int i = 1; i < acc_log.size(); i++) begin
            check("accept_gap", acc_log[i] - acc_log[i-1], TAPS + 2);
        end
        drain();

        // reset mid-MAC aborts the sample and clears the bank
        load_const(16'h2000);
        send(16'h3000);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        foreach (coef_m[k]) coef_m[k] = 0;
        foreach (hist[k]) hist[k] = 0;
        #1;
        check("rmac_ready", fready, 1'b1);
        check("rmac_valid", ovalid, 1'b0);
        check("rmac_out", dout, '0);
        check("rmac_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send(16'h3000);
        send(16'h4000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_direct_param.md
# fir_direct_param

Parametrised, time-multiplexed direct-form FIR filter. It succeeds the fixed 33-tap, 16-bit direct-form top. Taps, data width and coefficient width are generics. A single multiplier-accumulator iterates over the taps, and a valid/ready handshake replaces free-running sampling. The coefficient bank is loaded through the existing active-low RAM-style write port, and only while a coefficient-update window is open. The block sits between the sample source and the output sink, with the host owning the coefficient port.

## Interface
- TAPS, 33, number of filter taps (2..64)
- DATA_W, 16, input/output sample width, signed
- COEF_W, 16, coefficient width, signed
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output
- ADDR_W, 6, coefficient address width; must satisfy 2**ADDR_W >= TAPS
- iClk_12M  in  1  single clock
- iRsn  in  1  asynchronous, active-low reset
- iCoeffiUpdateFlag  in  1  high requests/holds the coefficient-update window
- iCsnRam  in  1  coefficient port chip select, active-low
- iWrnRam  in  1  coefficient port write enable, active-low
- iAddrRam  in  ADDR_W  coefficient index (0 = newest-sample tap)
- iWrDtRam  in  COEF_W  coefficient write data, signed
- iFirValid  in  1  input sample valid
- oFirReady  out  1  block accepts a sample this cycle
- iFirIn  in  DATA_W  input sample, signed
- oFirValid  out  1  oFirOut valid, one-cycle pulse
- oFirOut  out  DATA_W  filtered sample, signed
- oUpdBusy  out  1  coefficient-update window is open

## Operation
- FSM states and transitions:
  - IDLE -> UPDATE when iCoeffiUpdateFlag=1.
  - IDLE -> MAC on an accepted sample.
  - UPDATE -> IDLE when iCoeffiUpdateFlag=0.
  - MAC -> OUT after TAPS cycles.
  - OUT -> IDLE.
- Accept: a sample is accepted only when iFirValid & oFirReady.
  - oFirReady = (state==IDLE) & ~iCoeffiUpdateFlag.
  - If the update flag and a valid sample arrive in the same cycle, UPDATE wins and the sample is not accepted.
- Delay line: on accept, x[0] <= iFirIn and x[k] <= x[k-1]. Contents persist across UPDATE.
- MAC: the tap counter k runs 0..TAPS-1, one product per cycle: acc += coef[k]*x[k].
  - The accumulator is cleared on entry to MAC.
  - Accumulator width is DATA_W+COEF_W+$clog2(TAPS) and must never overflow.
- Output: rounded = (acc + 2**(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up). The result is reduced to DATA_W bits per the Configuration section.
- Coefficient writes: a write (iCsnRam=0, iWrnRam=0) takes effect only in UPDATE. It is ignored in every other state and when iAddrRam >= TAPS.
- iCoeffiUpdateFlag rising during MAC/OUT: the current computation completes with the old coefficients, then the FSM enters UPDATE.
- Reset: every coefficient, delay-line entry, accumulator and counter clears to 0; state goes to IDLE.
- Reset during MAC aborts the computation and no oFirValid is produced.

## Timing
- Reset values: oFirReady=1, oFirValid=0, oFirOut=0, oUpdBusy=0.
- Latency is TAPS+2 cycles from the accept edge to the oFirValid cycle. The sequence is accept at cycle 0, MAC cycles 1..TAPS, OUT at cycle TAPS+1, and oFirValid registered in the following cycle.
- Throughput is one sample per TAPS+2 cycles. oFirReady is low from the accept cycle+1 until the cycle after OUT.
- oFirOut is registered and holds its value until the next oFirValid.
- A coefficient write in UPDATE is visible to the next MAC; no read-back port exists.
- oUpdBusy is high exactly while the state is UPDATE.

## Configuration
- FIR_SATURATE_EN defined: a rounded value outside DATA_W range clamps to 2**(DATA_W-1)-1 or -2**(DATA_W-1).
- FIR_SATURATE_EN undefined: oFirOut takes the low DATA_W bits of the rounded value (two's-complement wrap).

## Structure
- Shared package fir_pkg holds:
  - the state enum {IDLE, UPDATE, MAC, OUT};
  - the accumulator-width function acc_w(DATA_W, COEF_W, TAPS);
  - the saturation/round helper function.
- One sub-module, fir_coef_bank: a TAPS x COEF_W register file with gated write enable and a combinational read at index k.
- Delay line, MAC and FSM live in the top module.

## Test plan
- Impulse response: load coef[k]=0x4000 for all k. Feed x=0x2000 then 40 zeros. Expect oFirOut=0x1000 for 33 outputs, then 0x0000.
- Tap ordering: load coef[k]=k. Feed impulse 0x8000 with OUT_SHIFT=0 and a 32-bit DATA_W bench build. Expect outputs 0, -32768, -65536, … in tap order.
- Saturation: all coef=0x7FFF, constant input 0x7FFF. With FIR_SATURATE_EN expect steady 0x7FFF; without it, expect the low 16 bits of the rounded sum.
- Update gating: a write outside UPDATE is ignored (output unchanged). A write to addr 40 in UPDATE is ignored. The update flag rising mid-MAC lets the current output finish with the old coefficients.
- Handshake: hold iFirValid=1 continuously. Expect exactly one accept per 35 cycles and oFirReady low while busy. Simultaneous flag and valid gives UPDATE and no accept.
- Reset mid-MAC: assert iRsn=0 at MAC cycle 10. Expect all outputs at reset values, no oFirValid, and coefficients cleared.
